// File: rtl/ntt_pipe_pkg.sv
// Shared constants and modular helpers for the Q = 65537 NTT pipeline.
package ntt_pipe_pkg;
  localparam int N = 17;
  localparam logic [N-1:0] Q = N'(65537);

  typedef struct packed {
    logic [4:0] e;
    logic       neg;
  } twiddle_t;

  // Every twiddle is +/-2^e; odd groups use the negation of their even partner.
  function automatic twiddle_t twiddle_exp(input int s, input int j);
    twiddle_t t;
    if (s == 0) begin
      t.e   = 5'd16;
      t.neg = 1'b0;
    end else begin
      t.e   = 5'((1 << (4 - s)) + (j & ~1));
      t.neg = j[0];
    end
    return t;
  endfunction

  function automatic logic [N-1:0] add_mod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= {1'b0, Q}) ? N'(sum - {1'b0, Q}) : N'(sum);
  endfunction

  function automatic logic [N-1:0] sub_mod(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a >= b) ? N'(a - b) : N'({1'b0, a} + {1'b0, Q} - {1'b0, b});
  endfunction
endpackage

// File: rtl/ntt_pipe_if.sv
// Streaming valid/ready bus for ntt_pipe: one D-lane coefficient vector per beat.
interface ntt_pipe_if import ntt_pipe_pkg::*; #(parameter int D = 8);
  logic           in_valid;
  logic           in_ready;
  logic [D*N-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [D*N-1:0] out_data;

  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/ntt_pipe_bf.sv
// Combinational Cooley-Tukey butterfly with a +/-2^e twiddle (shift and fold, no multiplier).
module ntt_pipe_bf import ntt_pipe_pkg::*; (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [4:0]   e,
  input  logic         neg,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi
);
  localparam int NW = N + 1;

  logic [33:0]   p;
  logic [NW-1:0] r;
  logic [N-1:0]  m, t;

  // 2^16 == -1 and 2^32 == 1 mod Q, so p folds to lo16 - mid16 + top; +Q keeps it positive.
  always_comb begin
    p  = 34'(b) << e;
    r  = NW'(p[15:0]) + NW'(p[33:32]) + NW'(Q) - NW'(p[31:16]);
    m  = (r >= NW'(Q)) ? N'(r - NW'(Q)) : N'(r);
    t  = (neg && m != '0) ? N'(Q - m) : m;
    lo = add_mod(a, t);
    hi = sub_mod(a, t);
  end
endmodule

// File: rtl/ntt_pipe.sv
// Pipelined D-point forward NTT over Q = 65537, one registered butterfly stage per level.
// Optional input range check and pre-reduction under NTT_PIPE_RANGE_CHECK_EN.
module ntt_pipe import ntt_pipe_pkg::*; #(
  parameter  int D  = 8,
  localparam int S  = $clog2(D),
  localparam int OW = $clog2(S + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  ntt_pipe_if.slave     bus,
  output logic [OW-1:0] occupancy,
  output logic          err
);
  typedef logic [D-1:0][N-1:0] vec_t;

  vec_t         lanes_in, pre;
  vec_t         stg_in [S];
  vec_t         bf_out [S];
  vec_t         stg_q  [S];
  logic [S-1:0] vld_pipe, vld_nxt, adv;

  assign lanes_in      = bus.in_data;
  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld_pipe[S-1];
  assign bus.out_data  = stg_q[S-1];

`ifdef NTT_PIPE_RANGE_CHECK_EN
  logic [D-1:0] oor;
  for (genvar i = 0; i < D; i++) begin : g_rc
    assign oor[i] = lanes_in[i] >= Q;
    assign pre[i] = oor[i] ? N'(lanes_in[i] - Q) : lanes_in[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 err <= 1'b0;
    else if (bus.in_valid && adv[0] && |oor)    err <= 1'b1;
  end
`else
  assign pre = lanes_in;
  assign err = 1'b0;
`endif

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int H = D >> (s + 1);
    if (s == 0) begin : g_head
      assign stg_in[s]  = pre;
      assign vld_nxt[s] = bus.in_valid;
    end else begin : g_link
      assign stg_in[s]  = stg_q[s-1];
      assign vld_nxt[s] = vld_pipe[s-1];
    end
    for (genvar j = 0; j < (1 << s); j++) begin : g_grp
      localparam twiddle_t TW = twiddle_exp(s, j);
      for (genvar k = 0; k < H; k++) begin : g_bf
        localparam int LO = j * 2 * H + k;
        ntt_pipe_bf u_bf (
          .a  (stg_in[s][LO]),
          .b  (stg_in[s][LO+H]),
          .e  (TW.e),
          .neg(TW.neg),
          .lo (bf_out[s][LO]),
          .hi (bf_out[s][LO+H])
        );
      end
    end
  end

  // A stage may load when empty or when its successor is moving: bubbles collapse.
  always_comb begin
    adv      = '0;
    adv[S-1] = !vld_pipe[S-1] || bus.out_ready;
    for (int s = S - 2; s >= 0; s--) adv[s] = !vld_pipe[s] || adv[s+1];
  end

  always_comb begin
    occupancy = '0;
    for (int s = 0; s < S; s++) occupancy = occupancy + OW'(vld_pipe[s]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int s = 0; s < S; s++) stg_q[s] <= '0;
    end else begin
      for (int s = 0; s < S; s++) begin
        if (adv[s]) begin
          vld_pipe[s] <= vld_nxt[s];
          stg_q[s]    <= bf_out[s];
        end
      end
    end
  end
endmodule

// File: tb/tb_ntt_pipe.sv
// Scoreboard bench for ntt_pipe: D=8 directed vectors and a D=32 random stream.
module tb_ntt_pipe;
  import ntt_pipe_pkg::*;

  localparam longint QI = 65537;
  typedef logic [8*17-1:0]  v8_t;
  typedef logic [32*17-1:0] v32_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_pipe_if #(.D(8))  b8 ();
  ntt_pipe_if #(.D(32)) b32 ();
  logic [1:0] occ8;
  logic [2:0] occ32;
  logic       err8, err32;

  ntt_pipe #(.D(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8),  .occupancy(occ8),  .err(err8));
  ntt_pipe #(.D(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32), .occupancy(occ32), .err(err32));

  int   n_chk = 0;
  int   n_err = 0;
  v8_t  q8 [$];
  logic dc8 [$];
  v32_t q32 [$];
  v8_t  e8, hold8;
  logic d8;
  v32_t e32;
  logic stream_done;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic v8_t v8(input int l [8]);
    v8_t r;
    for (int i = 0; i < 8; i++) r[17*i +: 17] = 17'(l[i]);
    return r;
  endfunction

  function automatic v8_t rep8(input int c);
    v8_t r;
    for (int i = 0; i < 8; i++) r[17*i +: 17] = 17'(c);
    return r;
  endfunction

  function automatic longint tw(input int s, input int j);
    longint w;
    int     e;
    if (s == 0) return 65536;
    e = (1 << (4 - s)) + j - (j % 2);
    w = 1;
    for (int i = 0; i < e; i++) w = (w * 2) % QI;
    return (j % 2 == 1) ? QI - w : w;
  endfunction

  // Straightforward modular-arithmetic model of the 32-point butterfly network.
  function automatic v32_t ref32(input v32_t v);
    longint x [32];
    longint a, t, w;
    int     h, lo;
    v32_t   r;
    for (int i = 0; i < 32; i++) x[i] = longint'(v[17*i +: 17]);
    for (int s = 0; s < 5; s++) begin
      h = 32 >> (s + 1);
      for (int j = 0; j < (1 << s); j++) begin
        w = tw(s, j);
        for (int k = 0; k < h; k++) begin
          lo        = j * 2 * h + k;
          t         = (w * x[lo+h]) % QI;
          a         = x[lo];
          x[lo]     = (a + t) % QI;
          x[lo+h]   = (a - t + QI) % QI;
        end
      end
    end
    for (int i = 0; i < 32; i++) r[17*i +: 17] = 17'(x[i]);
    return r;
  endfunction

  task automatic send8(input v8_t v, input logic dc, input v8_t exp);
    logic acc = 1'b0;
    b8.in_valid = 1'b1;
    b8.in_data  = v;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = b8.in_ready;
      @(posedge clk);
      #1;
    end
    b8.in_valid = 1'b0;
    if (acc) begin
      q8.push_back(exp);
      dc8.push_back(dc);
    end else chk("send8_accept_timeout", acc, 1);
  endtask

  task automatic send32(input v32_t v, input v32_t exp);
    logic acc = 1'b0;
    b32.in_valid = 1'b1;
    b32.in_data  = v;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge clk);
      acc = b32.in_ready;
      @(posedge clk);
      #1;
    end
    b32.in_valid = 1'b0;
    if (acc) q32.push_back(exp);
    else chk("send32_accept_timeout", acc, 1);
  endtask

  task automatic drain8(input string nm);
    for (int c = 0; c < 50 && q8.size() != 0; c++) @(posedge clk);
    @(posedge clk);
    #1;
    chk({nm, "_queue_empty"}, q8.size(), 0);
    chk({nm, "_occupancy"}, occ8, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) chk("out8_unexpected_valid", b8.out_valid, 0);
      else begin
        e8 = q8.pop_front();
        d8 = dc8.pop_front();
        if (!d8) begin
          n_chk++;
          if (b8.out_data !== e8) begin
            n_err++;
            $display("FAIL out8_data: got %h, required %h", b8.out_data, e8);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) chk("out32_unexpected_valid", b32.out_valid, 0);
      else begin
        e32 = q32.pop_front();
        n_chk++;
        if (b32.out_data !== e32) begin
          n_err++;
          $display("FAIL out32_data: got %h, required %h", b32.out_data, e32);
        end
      end
    end
  end

  initial begin
    b8.in_valid  = 1'b0; b8.in_data  = '0; b8.out_ready  = 1'b1;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.out_ready = 1'b1;
    stream_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_out_data_nonzero", longint'(|b8.out_data), 0);
    chk("rst_occupancy", occ8, 0);
    chk("rst_err", err8, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", b8.in_ready, 1);

    // Impulse with latency check: result visible three cycles after the accept cycle.
    send8(v8('{1, 0, 0, 0, 0, 0, 0, 0}), 1'b0, rep8(1));
    chk("latency_edge0", b8.out_valid, 0);
    @(posedge clk); #1;
    chk("latency_edge1", b8.out_valid, 0);
    @(posedge clk); #1;
    chk("latency_edge2", b8.out_valid, 1);
    send8(v8('{0, 0, 0, 0, 1, 0, 0, 0}), 1'b0,
          v8('{65536, 65536, 65536, 65536, 1, 1, 1, 1}));
    send8(v8('{0, 1, 0, 0, 0, 0, 0, 0}), 1'b0,
          v8('{16, 65521, 65521, 16, 64, 65473, 65473, 64}));
    send8(v8('{0, 65536, 0, 0, 0, 0, 0, 0}), 1'b0,
          v8('{65521, 16, 16, 65521, 65473, 64, 64, 65473}));
    drain8("directed");

    // Backpressure: three fill the pipe, the fourth waits.
    b8.out_ready = 1'b0;
    fork
      begin
        send8(v8('{1, 0, 0, 0, 0, 0, 0, 0}), 1'b0, rep8(1));
        send8(v8('{2, 0, 0, 0, 0, 0, 0, 0}), 1'b0, rep8(2));
        send8(v8('{0, 0, 0, 0, 3, 0, 0, 0}), 1'b0,
              v8('{65534, 65534, 65534, 65534, 3, 3, 3, 3}));
        send8(v8('{5, 0, 0, 0, 0, 0, 0, 0}), 1'b0, rep8(5));
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("bp_occupancy_full", occ8, 3);
        chk("bp_in_ready_low", b8.in_ready, 0);
        chk("bp_out_valid", b8.out_valid, 1);
        hold8 = b8.out_data;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_out_data_stable", longint'(b8.out_data === hold8), 1);
        b8.out_ready = 1'b1;
      end
    join
    drain8("backpressure");

    // Reset with two vectors in flight.
    send8(v8('{7, 0, 0, 0, 0, 0, 0, 0}), 1'b0, rep8(7));
    send8(v8('{9, 0, 0, 0, 0, 0, 0, 0}), 1'b0, rep8(9));
    chk("pre_reset_occupancy", occ8, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", b8.out_valid, 0);
    chk("midrst_occupancy", occ8, 0);
    q8.delete();
    dc8.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", b8.in_ready, 1);
    for (int c = 0; c < 5; c++) begin
      chk("post_reset_no_stale", b8.out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Out-of-range lane.
`ifdef NTT_PIPE_RANGE_CHECK_EN
    send8(v8('{65537, 0, 0, 0, 0, 0, 0, 0}), 1'b0, rep8(0));
    chk("range_err_set", err8, 1);
    send8(v8('{1, 0, 0, 0, 0, 0, 0, 0}), 1'b0, rep8(1));
    drain8("range");
    chk("range_err_sticky", err8, 1);
`else
    send8(v8('{65537, 0, 0, 0, 0, 0, 0, 0}), 1'b1, rep8(0));
    drain8("range");
    chk("range_err_tied_low", err8, 0);
`endif

    // D=32: hand-computed impulses, then random stream against the model.
    begin
      v32_t imp, ones, shf;
      imp = '0; imp[0 +: 17] = 17'd1;
      for (int i = 0; i < 32; i++) ones[17*i +: 17] = 17'd1;
      send32(imp, ones);
      imp = '0; imp[17*16 +: 17] = 17'd1;
      for (int i = 0; i < 32; i++) shf[17*i +: 17] = (i < 16) ? 17'd65536 : 17'd1;
      send32(imp, shf);
    end
    fork
      begin
        v32_t v;
        for (int n = 0; n < 100; n++) begin
          for (int i = 0; i < 32; i++) v[17*i +: 17] = 17'($urandom_range(65536, 0));
          send32(v, ref32(v));
          if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          b32.out_ready = 1'($urandom_range(1, 0));
        end
        b32.out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 100 && q32.size() != 0; c++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("stream_queue_empty", q32.size(), 0);
    chk("stream_occupancy", occ32, 0);
    chk("stream_err", err32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
